// File: rtl/lce_req_arb.sv
// Two-input LCE request arbiter: per-input FIFOs feeding one CCE-bound output,
// round-robin by default or D$-fixed priority when BP_LCE_REQ_ARB_FIXED_PRIO_EN is defined.
module lce_req_arb #(
    parameter int req_width_p = 128,
    parameter int fifo_els_p  = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [1:0][req_width_p-1:0] lce_req_i,
    input  logic [1:0]                  lce_req_v_i,
    output logic [1:0]                  lce_req_ready_o,
    output logic [req_width_p-1:0]      lce_req_o,
    output logic                        lce_req_src_o,
    output logic                        lce_req_v_o,
    input  logic                        lce_req_ready_i
);

    localparam int PW = $clog2(fifo_els_p);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(fifo_els_p);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    logic [req_width_p-1:0] r_mem [2][fifo_els_p];
    logic [1:0][PW-1:0]     r_rptr;
    logic [1:0][PW-1:0]     r_wptr;
    logic [1:0][CW-1:0]     r_cnt;
    logic [1:0][CW-1:0]     w_cnt_nxt;
    logic [1:0]             r_ready;
    logic [1:0]             w_enq;
    logic [1:0]             w_deq;
    logic [1:0]             w_nonempty;
    state_t                 r_state;
    logic                   r_lock_gnt;
    logic                   w_grant;
    logic                   w_prio;
    logic                   w_hs;

    // Ready comes straight from a register so a source may wait on it before raising valid.
    assign lce_req_ready_o = r_ready;
    assign w_enq           = lce_req_v_i & r_ready;
    assign w_nonempty[0]   = (r_cnt[0] != '0);
    assign w_nonempty[1]   = (r_cnt[1] != '0);

    assign lce_req_v_o   = |w_nonempty;
    assign w_hs          = lce_req_v_o & lce_req_ready_i;
    assign lce_req_src_o = w_grant;
    assign lce_req_o     = r_mem[w_grant][r_rptr[w_grant]];

`ifdef BP_LCE_REQ_ARB_FIXED_PRIO_EN
    assign w_prio = 1'b1;
`else
    logic r_prio;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_prio <= 1'b0;
        else if (w_hs)
            r_prio <= ~w_grant;
    end

    assign w_prio = r_prio;
`endif

    // With nothing buffered the grant parks on input 0 so src reads 0 when idle.
    always_comb begin
        w_grant = 1'b0;
        if (r_state == ST_LOCKED)
            w_grant = r_lock_gnt;
        else if (w_nonempty[w_prio])
            w_grant = w_prio;
        else if (w_nonempty[~w_prio])
            w_grant = ~w_prio;
    end

    always_comb begin
        w_deq     = '0;
        w_cnt_nxt = r_cnt;
        for (int n = 0; n < 2; n++) begin
            w_deq[n]     = w_hs & (w_grant == 1'(n));
            w_cnt_nxt[n] = r_cnt[n] + CW'(w_enq[n]) - CW'(w_deq[n]);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_ready <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_enq[n])
                    r_wptr[n] <= r_wptr[n] + 1'b1;
                if (w_deq[n])
                    r_rptr[n] <= r_rptr[n] + 1'b1;
                r_cnt[n]   <= w_cnt_nxt[n];
                r_ready[n] <= (w_cnt_nxt[n] != FULL_CNT);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < 2; n++)
            if (w_enq[n])
                r_mem[n][r_wptr[n]] <= lce_req_i[n];
    end

    // A presented-but-stalled packet locks the grant so the output holds steady.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_lock_gnt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lce_req_v_o & ~lce_req_ready_i) begin
                        r_state    <= ST_LOCKED;
                        r_lock_gnt <= w_grant;
                    end
                end
                ST_LOCKED: begin
                    if (w_hs)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lce_req_arb.sv
// Scoreboard bench for lce_req_arb: directed streams push expected {src,pkt}
// into a queue, a negedge monitor pops on every output handshake.
module tb_lce_req_arb;
    localparam int W = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0][W-1:0] req_i;
    logic [1:0]        v_i;
    logic [1:0]        rdy_o;
    logic [W-1:0]      req_o;
    logic              src_o;
    logic              v_o;
    logic              rdy_i = 1'b0;
    logic              v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0]      d0 = '0, d1 = '0;
    logic [W:0]        exp_q[$];
    int                n_tests = 0;
    int                n_fail = 0;

    assign v_i   = {v1, v0};
    assign req_i = {d1, d0};

    lce_req_arb #(.req_width_p(W), .fifo_els_p(2)) dut (
        .clk_i(clk), .reset_i(rst),
        .lce_req_i(req_i), .lce_req_v_i(v_i), .lce_req_ready_o(rdy_o),
        .lce_req_o(req_o), .lce_req_src_o(src_o), .lce_req_v_o(v_o),
        .lce_req_ready_i(rdy_i)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input int x);
        return W'(x);
    endfunction

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && v_o && rdy_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %h expected no output", {src_o, req_o});
            end else
                chk("out_pkt", {src_o, req_o}, exp_q.pop_front());
        end
    end

    task automatic send(input int n, input logic [W-1:0] d);
        int k = 0;
        if (n == 0) begin v0 = 1'b1; d0 = d; end
        else        begin v1 = 1'b1; d1 = d; end
        forever begin
            @(negedge clk);
            if (rdy_o[n]) break;
            k++;
            if (k > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout in%0d: ready 0 expected 1", n);
                break;
            end
        end
        @(posedge clk); #1;
        if (n == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        chk("drain_left", W'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rdy_i = 1'b0;
        #1;
        chk("rst_ready", rdy_o, 2'b00);
        chk("rst_v", v_o, 1'b0);
        chk("rst_src", src_o, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", rdy_o, 2'b11);
        chk("post_rst_v", v_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset values and first-edge ready
        do_reset();

        // both inputs streaming, output always ready
        do_reset();
        rdy_i = 1'b1;
`ifdef BP_LCE_REQ_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, pk('hB0 + i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, pk('hA0 + i)});
`else
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, pk('hA0 + i)});
            exp_q.push_back({1'b1, pk('hB0 + i)});
        end
`endif
        fork
            begin for (int i = 0; i < 4; i++) send(0, pk('hA0 + i)); end
            begin for (int i = 0; i < 4; i++) send(1, pk('hB0 + i)); end
        join
        drain(40);

        // stalled output holds A from input 0 while B waits
        do_reset();
        exp_q.push_back({1'b0, pk('hA5A5)});
        exp_q.push_back({1'b1, pk('hB5B5)});
        send(0, pk('hA5A5));
        chk("latency_v", v_o, 1'b1);
        chk("latency_pkt", {src_o, req_o}, {1'b0, pk('hA5A5)});
        send(1, pk('hB5B5));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_v", v_o, 1'b1);
            chk("hold_pkt", {src_o, req_o}, {1'b0, pk('hA5A5)});
        end
        @(posedge clk); #1;
        rdy_i = 1'b1;
        drain(10);

        // input 0 overfills a depth-2 FIFO under backpressure
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, pk('hC0 + i)});
        fork
            begin for (int i = 0; i < 3; i++) send(0, pk('hC0 + i)); end
            begin
                repeat (4) @(negedge clk);
                chk("full_ready0", rdy_o[0], 1'b0);
                chk("full_ready1", rdy_o[1], 1'b1);
                chk("full_head", {src_o, req_o}, {1'b0, pk('hC0)});
                @(posedge clk); #1;
                rdy_i = 1'b1;
            end
        join
        drain(20);

        // reset with both FIFOs full discards everything
        do_reset();
        fork
            begin send(0, pk('hD0)); send(0, pk('hD1)); end
            begin send(1, pk('hE0)); send(1, pk('hE1)); end
        join
        @(negedge clk);
        chk("both_full_ready", rdy_o, 2'b00);
        chk("both_full_v", v_o, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_v", v_o, 1'b0);
        chk("async_rst_ready", rdy_o, 2'b00);
        chk("async_rst_src", src_o, 1'b0);
        rdy_i = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_flush_v", v_o, 1'b0);
        end
        chk("post_flush_ready", rdy_o, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
